// File: rtl/freq_div_ctrl.sv
// Programmable clock divider with handshake reconfiguration.
// Divisor changes are deferred to the end of the running output period.
module freq_div_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t       r_state, w_nxt_state;
  logic [W-1:0] r_cnt, w_nxt_cnt;
  logic [W-1:0] r_n, w_nxt_n;
  logic [W-1:0] r_pend, w_nxt_pend;

  logic         w_accept;
  logic         w_illegal;
  logic         w_req;
  logic         w_last;
  logic         w_apply;
  logic [W-1:0] w_apply_val;
  logic [W-1:0] w_half;
  logic         w_nxt_clk;
  logic         w_nxt_tick;

  assign w_accept  = cfg_valid && cfg_ready;
  assign w_illegal = w_accept && (cfg_div == W'(1));
  assign w_req     = w_accept && !w_illegal;
  assign w_last    = (r_cnt == r_n - W'(1));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_n     = r_n;
    w_nxt_pend  = r_pend;
    w_apply     = 1'b0;
    w_apply_val = '0;

    case (r_state)
      IDLE: begin
        if (w_req && (cfg_div != '0)) begin
          w_nxt_state = RUN;
          w_nxt_n     = cfg_div;
          w_nxt_cnt   = '0;
        end
      end
      RUN: begin
        if (w_last) begin
          w_nxt_cnt = '0;
          if (w_req) begin
            w_apply     = 1'b1;
            w_apply_val = cfg_div;
          end
        end else begin
          w_nxt_cnt = r_cnt + W'(1);
          if (w_req) begin
            w_nxt_pend  = cfg_div;
            w_nxt_state = SWITCH;
          end
        end
      end
      SWITCH: begin
        if (w_last) begin
          w_nxt_cnt   = '0;
          w_apply     = 1'b1;
          w_apply_val = r_pend;
          w_nxt_pend  = '0;
        end else begin
          w_nxt_cnt = r_cnt + W'(1);
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
        w_nxt_n     = '0;
        w_nxt_pend  = '0;
      end
    endcase

    // Period boundary: new divisor starts a fresh period, zero stops.
    if (w_apply) begin
      w_nxt_cnt = '0;
      if (w_apply_val == '0) begin
        w_nxt_state = IDLE;
        w_nxt_n     = '0;
      end else begin
        w_nxt_state = RUN;
        w_nxt_n     = w_apply_val;
      end
    end
  end

  // Outputs are registered from next-state values so they align with the counter.
  assign w_half     = {1'b0, w_nxt_n[W-1:1]} + {{(W-1){1'b0}}, w_nxt_n[0]};
  assign w_nxt_clk  = (w_nxt_state != IDLE) && (w_nxt_cnt < w_half);
  assign w_nxt_tick = (w_nxt_state != IDLE) && (w_nxt_cnt == w_nxt_n - W'(1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_n       <= '0;
      r_pend    <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_n       <= w_nxt_n;
      r_pend    <= w_nxt_pend;
      cfg_ready <= (w_nxt_state != SWITCH);
      cfg_err   <= w_illegal;
      clk_out   <= w_nxt_clk;
      tick      <= w_nxt_tick;
      busy      <= (w_nxt_state != IDLE);
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: a cycle-indexed period model predicts
// {clk_out,tick,busy,cfg_ready,cfg_err}; a monitor compares every cycle.
module tb_freq_div_ctrl;
  localparam int unsigned W = 8;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready, cfg_err, clk_out, tick, busy;

  freq_div_ctrl #(.W(W)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  // Reference model: periods are located by absolute cycle index.
  int c = 0;
  bit m_run = 0;
  int m_n = 0;
  int m_start = 0;
  bit m_pv = 0;
  int m_pend = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b (clk_out,tick,busy,ready,err)",
                  name, $time, got[4:0], exp[4:0]);
  endtask

  function automatic logic [4:0] dut_vec();
    return {clk_out, tick, busy, cfg_ready, cfg_err};
  endfunction

  task automatic apply(input int x);
    if (x == 0) m_run = 0;
    else begin
      m_n = x;
      m_start = c + 1;
    end
  endtask

  task automatic model_edge(input bit v, input int d, output logic [4:0] e);
    int p;
    bit bnd, acc, err;
    bnd = 0;
    if (m_run) begin
      p = (c - m_start) % m_n;
      bnd = (p == m_n - 1);
    end
    acc = v && !m_pv;
    err = acc && (d == 1);
    if (acc && d != 1) begin
      if (!m_run) begin
        if (d >= 2) begin
          m_run = 1;
          m_n = d;
          m_start = c + 1;
        end
      end else if (bnd) apply(d);
      else begin
        m_pv = 1;
        m_pend = d;
      end
    end else if (bnd && m_pv) begin
      apply(m_pend);
      m_pv = 0;
    end
    c++;
    if (m_run) begin
      p = (c - m_start) % m_n;
      e = {p < (m_n + 1) / 2, p == m_n - 1, 1'b1, !m_pv, err};
    end else e = {1'b0, 1'b0, 1'b0, 1'b1, err};
  endtask

  task automatic step(input bit v, input int d);
    logic [4:0] e;
    @(negedge clk_in);
    cfg_valid = v;
    cfg_div   = W'(d);
    model_edge(v, d, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  always @(posedge clk_in) begin
    #1;
    if (exp_q.size() > 0) check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_div = '0;
    @(posedge clk_in);
    #2;
    check("reset_hold", 32'(dut_vec()), 32'(5'b00010));
    @(negedge clk_in);
    rst = 1'b0;
    idle(3);

    // N=4 then N=5 from idle/boundary
    step(1, 4); idle(12);
    step(0, 0); idle(2);
    step(1, 0); idle(3);
    step(1, 5); idle(15);
    step(1, 0); idle(8);

    // N=6 running, switch to 3 at count 1
    step(1, 6); step(0, 0); step(1, 3); idle(14);
    step(1, 0); idle(6);

    // N=4, stop at boundary count 3
    step(1, 4); idle(3); step(1, 0); idle(4);

    // N=8, illegal request mid-period
    step(1, 8); idle(5); step(1, 1); idle(12);
    step(1, 1); idle(3);

    // N=7, asynchronous reset at count 2
    step(1, 7); idle(2);
    @(posedge clk_in);
    #3;
    check("pre_reset_clk", 32'(clk_out), 32'(1));
    rst = 1'b1;
    #1;
    check("async_reset", 32'(dut_vec()), 32'(5'b00010));
    m_run = 0;
    m_pv = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    idle(6);

    // randomized requests
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = $urandom_range(0, 15);
      if (r == 15) d = $urandom_range(2, (1 << W) - 1);
      else d = r;
      step($urandom_range(0, 5) == 0, d);
    end
    step(1, 0);
    idle(300);

    @(posedge clk_in);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
